// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register and default parameter values.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_LOAD_STALL_CYCLES = 1;
    localparam int DEF_CNT_W             = 16;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the load sitting in ID/EX writes a register
// that the instruction in IF/ID reads. Purely combinational so the same
// compare can be shared with the forwarding logic.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       lu_hazard
);

    logic rs_match;
    logic rt_match;

    // rt only matters when the consumer actually reads it as a source;
    // $0 is hard-wired so a load into it can never feed a consumer.
    always_comb begin
        rs_match  = (idex_rt == ifid_rs);
        rt_match  = ifid_uses_rt && (idex_rt == ifid_rt);
        lu_hazard = idex_mem_read && (idex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard controller: stalls PC and IF/ID and bubbles ID/EX on a
// load-use hazard (optionally for several cycles), flushes the front of the
// pipe when a branch resolves taken in MEM, and keeps saturating statistics.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic             Clk_in,
    input  logic             Reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic             EXMEM_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Bubbles still owed after the first one, loaded on entry to STALL.
    localparam logic [2:0] INIT_REMAIN = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hdu_state_e       state_q, state_d;
    logic [2:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hazard;
    logic             stall_inc;
    logic             flush_inc;

    load_use_detect u_lu (
        .idex_mem_read (IDEX_MemRead),
        .idex_rt       (IDEX_rt),
        .ifid_rs       (IFID_rs),
        .ifid_rt       (IFID_rt),
        .ifid_uses_rt  (IFID_UsesRt),
        .lu_hazard     (lu_hazard)
    );

    // Next-state and control outputs; a taken branch beats any stall since
    // the stalled instructions are on the wrong path anyway.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;

        if (Reset) begin
            // Hold the pipe completely quiet while in reset.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (EXMEM_BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
            remain_d    = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hazard) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                        stall_inc   = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d  = STALL;
                            remain_d = INIT_REMAIN;
                        end
                    end
                end
                STALL: begin
                    // The hazard input is not re-evaluated while stalled.
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_Bubble = 1'b1;
                    stall_inc   = 1'b1;
                    remain_d    = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    remain_d = 3'd0;
                end
            endcase
        end

        stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    // State, remaining-bubble counter and statistics registers.
    always_ff @(posedge Clk_in or posedge Reset) begin
        if (Reset) begin
            state_q     <= RUN;
            remain_q    <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: three configurations share one stimulus
// bus (default, 3-cycle load stall, 4-bit counters). Control expectations go
// into a scoreboard queue when a vector is driven and are popped and compared
// once the combinational outputs have settled.
module tb_hazard_detection_unit;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] idex_rt;
    logic       br_taken;

    logic        pc1, iw1, bub1, iff1, idf1, emf1;
    logic        pc3, iw3, bub3, iff3, idf3, emf3;
    logic        pc4, iw4, bub4, iff4, idf4, emf4;
    logic [15:0] sc1, fc1, sc3, fc3;
    logic [3:0]  sc4, fc4;

    int n_chk  = 0;
    int n_fail = 0;

    // control vector = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush}
    localparam logic [5:0] C_NORM  = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b001000;
    localparam logic [5:0] C_FLUSH = 6'b110111;
    localparam logic [5:0] C_RST   = 6'b000000;

    hazard_detection_unit u_d1 (
        .Clk_in(clk), .Reset(rst), .IFID_rs(ifid_rs), .IFID_rt(ifid_rt),
        .IFID_UsesRt(uses_rt), .IDEX_MemRead(mem_read), .IDEX_rt(idex_rt),
        .EXMEM_BranchTaken(br_taken), .PCWrite(pc1), .IFIDWrite(iw1),
        .IDEX_Bubble(bub1), .IFID_Flush(iff1), .IDEX_Flush(idf1),
        .EXMEM_Flush(emf1), .StallCount(sc1), .FlushCount(fc1)
    );

    hazard_detection_unit #(.LOAD_STALL_CYCLES(3)) u_d3 (
        .Clk_in(clk), .Reset(rst), .IFID_rs(ifid_rs), .IFID_rt(ifid_rt),
        .IFID_UsesRt(uses_rt), .IDEX_MemRead(mem_read), .IDEX_rt(idex_rt),
        .EXMEM_BranchTaken(br_taken), .PCWrite(pc3), .IFIDWrite(iw3),
        .IDEX_Bubble(bub3), .IFID_Flush(iff3), .IDEX_Flush(idf3),
        .EXMEM_Flush(emf3), .StallCount(sc3), .FlushCount(fc3)
    );

    hazard_detection_unit #(.CNT_W(4)) u_d4 (
        .Clk_in(clk), .Reset(rst), .IFID_rs(ifid_rs), .IFID_rt(ifid_rt),
        .IFID_UsesRt(uses_rt), .IDEX_MemRead(mem_read), .IDEX_rt(idex_rt),
        .EXMEM_BranchTaken(br_taken), .PCWrite(pc4), .IFIDWrite(iw4),
        .IDEX_Bubble(bub4), .IFID_Flush(iff4), .IDEX_Flush(idf4),
        .EXMEM_Flush(emf4), .StallCount(sc4), .FlushCount(fc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         dut;
        logic [5:0] exp;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] irt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [5:0] get_ctl(input int dut);
        case (dut)
            1:       return {pc1, iw1, bub1, iff1, idf1, emf1};
            3:       return {pc3, iw3, bub3, iff3, idf3, emf3};
            default: return {pc4, iw4, bub4, iff4, idf4, emf4};
        endcase
    endfunction

    task automatic push(input string nm, input int mask, input logic [5:0] exp);
        exp_t e;
        e.name = nm;
        e.exp  = exp;
        if (mask[0]) begin e.dut = 1; sbq.push_back(e); end
        if (mask[1]) begin e.dut = 3; sbq.push_back(e); end
        if (mask[2]) begin e.dut = 4; sbq.push_back(e); end
    endtask

    task automatic drain();
        exp_t e;
        logic [5:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = get_ctl(e.dut);
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s dut%0d: ctl got %b expected %b", e.name, e.dut, act, e.exp);
            end
        end
    endtask

    task automatic chk_cnt(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, let outputs settle, compare, advance one cycle.
    task automatic step(input string nm, input int mask, input logic mr, input logic [4:0] irt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic br, input logic [5:0] exp);
        mem_read = mr;
        idex_rt  = irt;
        ifid_rs  = rs;
        ifid_rt  = rt;
        uses_rt  = uses;
        br_taken = br;
        push(nm, mask, exp);
        #3;
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0;
        ifid_rt = 5'd0; uses_rt = 1'b0; br_taken = 1'b0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{"idle",        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_NORM};
        tbl[1]  = '{"lu_rs",       1'b1, 5'd8,  5'd8,  5'd2,  1'b0, 1'b0, C_STALL};
        tbl[2]  = '{"after_lu",    1'b0, 5'd8,  5'd8,  5'd2,  1'b0, 1'b0, C_NORM};
        tbl[3]  = '{"rt_no_use",   1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b0, C_NORM};
        tbl[4]  = '{"rt_use",      1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, C_STALL};
        tbl[5]  = '{"load_r0_rs",  1'b1, 5'd0,  5'd0,  5'd4,  1'b0, 1'b0, C_NORM};
        tbl[6]  = '{"load_r0_rt",  1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, C_NORM};
        tbl[7]  = '{"branch",      1'b0, 5'd0,  5'd1,  5'd2,  1'b0, 1'b1, C_FLUSH};
        tbl[8]  = '{"branch_lu",   1'b1, 5'd5,  5'd5,  5'd2,  1'b0, 1'b1, C_FLUSH};
        tbl[9]  = '{"lu_rt31",     1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0, C_STALL};
        tbl[10] = '{"no_load",     1'b0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, C_NORM};

        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: quiet outputs, counters cleared.
        step("in_reset", 7, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_RST);
        chk_cnt("rst_sc1", int'(sc1), 0);
        chk_cnt("rst_fc1", int'(fc1), 0);
        rst = 1'b0;

        // Single-bubble configurations run the vector table.
        foreach (tbl[i])
            step(tbl[i].name, 5, tbl[i].mr, tbl[i].irt, tbl[i].rs, tbl[i].rt,
                 tbl[i].uses, tbl[i].br, tbl[i].exp);
        chk_cnt("tbl_sc1", int'(sc1), 3);
        chk_cnt("tbl_fc1", int'(fc1), 2);
        chk_cnt("tbl_sc4", int'(sc4), 3);

        // Reset asserted mid-cycle while a hazard is present.
        mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        #1;
        push("pre_rst_stall", 1, C_STALL);
        drain();
        rst = 1'b1;
        #1;
        push("mid_rst", 7, C_RST);
        drain();
        chk_cnt("mid_rst_sc1", int'(sc1), 0);
        chk_cnt("mid_rst_fc1", int'(fc1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 7, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_NORM);

        // Multi-cycle stall: one hazard pulse yields three bubbles.
        reset_pulse();
        step("mc_b1", 2, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc_b2", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc_b3", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc_run", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_NORM);
        chk_cnt("mc_sc3", int'(sc3), 3);
        // Hazard still visible while stalled must not extend the stall.
        step("mc2_b1", 2, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc2_b2", 2, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc2_b3", 2, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, C_STALL);
        step("mc2_end", 2, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, C_NORM);
        chk_cnt("mc2_sc3", int'(sc3), 6);

        // Branch on the second bubble aborts the stall.
        reset_pulse();
        step("bs_b1", 2, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_STALL);
        step("bs_br", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, C_FLUSH);
        step("bs_run", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_NORM);
        step("bs_run2", 2, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_NORM);
        chk_cnt("bs_sc3", int'(sc3), 1);
        chk_cnt("bs_fc3", int'(fc3), 1);

        // Saturation: 20 hazards on the 4-bit counter stick at 15.
        reset_pulse();
        for (int k = 0; k < 20; k++)
            step("sat_lu", 5, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_STALL);
        chk_cnt("sat_sc4", int'(sc4), 15);
        chk_cnt("sat_sc1", int'(sc1), 20);
        chk_cnt("sat_fc4", int'(fc4), 0);
        step("sat_run", 5, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, C_NORM);
        chk_cnt("sat_sc4_hold", int'(sc4), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
